window_gen_3x3: RTL and testbench

- Upstream feeder for the 3x3 Smoothening stage.
- Accepts a raster pixel stream at two horizontally adjacent 8-bit pixels per beat, buffers two previous lines, and emits two 3x3 neighbourhoods per beat: one per lane, centred on adjacent columns.
- Output layout matches the smoothing input `image[8:0][1:0]` exactly, so the two blocks connect without glue.
- Emits only windows lying fully inside the frame (no border padding).

---
 rtl/img_pkg.sv | 11 +
 rtl/window_gen_3x3_if.sv | 28 ++
 rtl/line_buffer.sv | 23 ++
 rtl/window_gen_3x3.sv | 123 ++++++++++++
 tb/tb_window_gen_3x3.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// Shared pixel/window types for the 3x3 window generator and the smoothing stage behind it.
// Two lanes of adjacent pixels per beat; a window is nine pixels per lane.
package img_pkg;
  localparam int PIX_W = 8;
  localparam int LANES = 2;
  localparam int WIN   = 9;

  typedef logic [PIX_W-1:0]          pix_t;
  typedef pix_t [LANES-1:0]          lane_pair_t;
  typedef pix_t [WIN-1:0][LANES-1:0] window_t;
endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel-stream in / window-stream out bundle; master drives pixels, slave (the generator) returns windows.
// No ready signals: the stream is valid-only with an always-ready consumer.
interface window_gen_3x3_if #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic                 in_valid;
  logic                 sof;
  img_pkg::lane_pair_t  pix_in;
  logic                 out_valid;
  img_pkg::window_t     window;
  logic [RW-1:0]        out_row;
  logic [CW-1:0]        out_col;
  logic                 frame_done;

  modport master (
    output in_valid, sof, pix_in,
    input  out_valid, window, out_row, out_col, frame_done
  );

  modport slave (
    input  in_valid, sof, pix_in,
    output out_valid, window, out_row, out_col, frame_done
  );
endinterface

// File: rtl/line_buffer.sv
// One-line pixel store: combinational read of the old word, write of the new word at the clock edge.
// Read data is available in the same cycle as the address; no backpressure.
module line_buffer #(
  parameter int  DEPTH = 320,
  parameter int  DW    = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end
endmodule

// File: rtl/window_gen_3x3.sv
// Turns a 2-pixel/beat raster stream into two fully-inside 3x3 windows per beat (one per lane).
// Outputs are registered one cycle after the qualifying beat; no backpressure, in_valid gaps just stall.
module window_gen_3x3
  import img_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input logic             clk,
  input logic             reset,
  window_gen_3x3_if.slave io
);
  localparam int BPL = IMG_W / 2;
  localparam int KW  = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int RW  = $clog2(IMG_H);
  localparam int CW  = $clog2(IMG_W);
  localparam logic [KW-1:0] K_LAST = KW'(BPL - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

  logic [KW-1:0] k_q, cur_k;
  logic [RW-1:0] r_q, cur_r;
  logic [CW-1:0] col_x2;
  logic          last_k, last_r, qual;

  lane_pair_t lb0_rd, lb1_rd;
  lane_pair_t prev_top, prev_mid, prev_bot;
  lane_pair_t rows_prev [3];
  lane_pair_t rows_cur  [3];
  window_t    win_nxt;

  logic          out_valid_q, frame_done_q;
  window_t       window_q;
  logic [RW-1:0] out_row_q;
  logic [CW-1:0] out_col_q;

  // sof overrides the running position so a restart can happen on any beat.
  always_comb begin
    cur_k = io.sof ? '0 : k_q;
    cur_r = io.sof ? '0 : r_q;
  end

  assign col_x2 = {cur_k, 1'b0};
  assign last_k = (cur_k == K_LAST);
  assign last_r = (cur_r == R_LAST);
  assign qual   = io.in_valid && (cur_r >= RW'(2)) && (cur_k != '0);

  line_buffer #(.DEPTH(BPL), .DW(2 * PIX_W)) u_lb1 (
    .clk   (clk),
    .we    (io.in_valid),
    .addr  (cur_k),
    .wdata (io.pix_in),
    .rdata (lb1_rd)
  );

  line_buffer #(.DEPTH(BPL), .DW(2 * PIX_W)) u_lb0 (
    .clk   (clk),
    .we    (io.in_valid),
    .addr  (cur_k),
    .wdata (lb1_rd),
    .rdata (lb0_rd)
  );

  assign rows_prev[0] = prev_top;
  assign rows_prev[1] = prev_mid;
  assign rows_prev[2] = prev_bot;
  assign rows_cur[0]  = lb0_rd;
  assign rows_cur[1]  = lb1_rd;
  assign rows_cur[2]  = io.pix_in;

  // Columns 2k-2, 2k-1 come from the previous beat; 2k, 2k+1 from the current one.
  always_comb begin
    win_nxt = '0;
    for (int rr = 0; rr < 3; rr++) begin
      win_nxt[3*rr + 0][0] = rows_prev[rr][0];
      win_nxt[3*rr + 1][0] = rows_prev[rr][1];
      win_nxt[3*rr + 2][0] = rows_cur[rr][0];
      win_nxt[3*rr + 0][1] = rows_prev[rr][1];
      win_nxt[3*rr + 1][1] = rows_cur[rr][0];
      win_nxt[3*rr + 2][1] = rows_cur[rr][1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q          <= '0;
      r_q          <= '0;
      prev_top     <= '0;
      prev_mid     <= '0;
      prev_bot     <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      window_q     <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      out_valid_q  <= qual;
      frame_done_q <= qual && last_k && last_r;
      if (io.in_valid) begin
        prev_top <= lb0_rd;
        prev_mid <= lb1_rd;
        prev_bot <= io.pix_in;
        if (last_k) begin
          k_q <= '0;
          r_q <= last_r ? '0 : cur_r + RW'(1);
        end else begin
          k_q <= cur_k + KW'(1);
          r_q <= cur_r;
        end
      end
      if (qual) begin
        window_q  <= win_nxt;
        out_row_q <= cur_r - RW'(1);
        out_col_q <= col_x2 - CW'(1);
      end
    end
  end

  assign io.out_valid  = out_valid_q;
  assign io.frame_done = frame_done_q;
  assign io.window     = window_q;
  assign io.out_row    = out_row_q;
  assign io.out_col    = out_col_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 on an 8x4 frame: image-array reference model checked every cycle,
// plus literal expectations for the ramp, stall, restart, reset and constant-frame cases.
module tb_window_gen_3x3;
  localparam int W     = 8;
  localparam int H     = 4;
  localparam int BPL   = W / 2;
  localparam int BEATS = BPL * H;

  logic clk;
  logic rst;

  window_gen_3x3_if #(.IMG_W(W), .IMG_H(H)) io ();

  window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .reset (rst),
    .io    (io)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: whole-frame image indexed by (row, column), position from a beat index.
  logic [7:0]         img [H][W];
  logic               exp_valid, exp_fd;
  img_pkg::window_t   exp_win;
  logic [$clog2(H)-1:0] exp_row;
  logic [$clog2(W)-1:0] exp_col;
  int cyc = 0;
  int sof_cyc = 0;

  initial begin
    int idx, r, k;
    idx = 0;
    exp_valid = 0; exp_fd = 0; exp_win = '0; exp_row = '0; exp_col = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        idx = 0;
        exp_valid = 0; exp_fd = 0; exp_win = '0; exp_row = '0; exp_col = '0;
      end else begin
        cyc++;
        exp_valid = 0;
        exp_fd    = 0;
        if (io.in_valid) begin
          if (io.sof) begin
            idx = 0;
            sof_cyc = cyc;
          end
          r = idx / BPL;
          k = idx % BPL;
          img[r][2*k]   = io.pix_in[0];
          img[r][2*k+1] = io.pix_in[1];
          if (r >= 2 && k >= 1) begin
            exp_valid = 1;
            exp_fd    = (r == H - 1) && (k == BPL - 1);
            exp_row   = ($clog2(H))'(r - 1);
            exp_col   = ($clog2(W))'(2*k - 1);
            for (int ln = 0; ln < 2; ln++)
              for (int rr = 0; rr < 3; rr++)
                for (int cc = 0; cc < 3; cc++)
                  exp_win[3*rr+cc][ln] = img[r-2+rr][2*k-2+ln+cc];
          end
          idx = (idx + 1) % BEATS;
        end
      end
    end
  end

  // Per-cycle comparison and statistics for the directed checks.
  int valid_cnt, fd_cnt, first_cyc;
  bit first_seen, const_phase;
  img_pkg::window_t first_win, last_win;
  logic [$clog2(H)-1:0] first_row, last_row;
  logic [$clog2(W)-1:0] first_col, last_col;

  initial begin
    int sum;
    valid_cnt = 0; fd_cnt = 0; first_seen = 0; const_phase = 0; first_cyc = 0;
    forever begin
      @(negedge clk);
      check("out_valid",  io.out_valid,  exp_valid);
      check("frame_done", io.frame_done, exp_fd);
      check("window",     io.window,     exp_win);
      check("out_row",    io.out_row,    exp_row);
      check("out_col",    io.out_col,    exp_col);
      if (io.out_valid) begin
        valid_cnt++;
        if (!first_seen) begin
          first_seen = 1;
          first_cyc  = cyc;
          first_win  = io.window;
          first_row  = io.out_row;
          first_col  = io.out_col;
        end
        if (const_phase) begin
          for (int ln = 0; ln < 2; ln++) begin
            sum = 0;
            for (int j = 0; j < 9; j++) sum += io.window[j][ln];
            check("const_avg", sum / 9, 255);
          end
        end
      end
      if (io.frame_done) begin
        fd_cnt++;
        last_win = io.window;
        last_row = io.out_row;
        last_col = io.out_col;
      end
    end
  end

  function automatic logic [7:0] pixel(input int mode, input int r, input int c);
    if (mode == 0) return 8'(16 * r + c);
    if (mode == 1) return 8'd255;
    return 8'($urandom);
  endfunction

  task automatic send_frame(input int mode, input int nbeats, input bit with_sof, input bit stalls);
    int r, k, g;
    for (int b = 0; b < nbeats; b++) begin
      r = (b / BPL) % H;
      k = b % BPL;
      @(negedge clk);
      io.in_valid  = 1'b1;
      io.sof       = (b == 0) && with_sof;
      io.pix_in[0] = pixel(mode, r, 2*k);
      io.pix_in[1] = pixel(mode, r, 2*k + 1);
      if (stalls && $urandom_range(0, 2) == 0) begin
        g = $urandom_range(1, 5);
        repeat (g) begin
          @(negedge clk);
          io.in_valid = 1'b0;
          io.sof      = 1'b0;
          io.pix_in   = 16'($urandom);
        end
      end
    end
    @(negedge clk);
    io.in_valid = 1'b0;
    io.sof      = 1'b0;
  endtask

  task automatic clear_stats();
    valid_cnt = 0; fd_cnt = 0; first_seen = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"},  io.out_valid,  0);
    check({tag, "_window"}, io.window,     0);
    check({tag, "_row"},    io.out_row,    0);
    check({tag, "_col"},    io.out_col,    0);
    check({tag, "_fd"},     io.frame_done, 0);
  endtask

  int lane0_exp[9] = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
  int lane1_exp[9] = '{1, 2, 3, 17, 18, 19, 33, 34, 35};

  initial begin
    rst = 1'b0;
    io.in_valid = 1'b0;
    io.sof      = 1'b0;
    io.pix_in   = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b1;

    // Ramp, two frames back to back (sof only on the first).
    clear_stats();
    send_frame(0, 2 * BEATS, 1, 0);
    repeat (2) @(negedge clk);
    check("ramp_first_delay", first_cyc - sof_cyc, 9);
    for (int j = 0; j < 9; j++) begin
      check("ramp_lane0", first_win[j][0], lane0_exp[j]);
      check("ramp_lane1", first_win[j][1], lane1_exp[j]);
    end
    check("ramp_first_row", first_row, 1);
    check("ramp_first_col", first_col, 1);
    check("ramp_valid_cnt", valid_cnt, 12);
    check("ramp_fd_cnt",    fd_cnt, 2);
    check("ramp_last_row",  last_row, 2);
    check("ramp_last_col",  last_col, 5);
    check("ramp_last_br",   last_win[8][1], 55);

    // Random stalls on the same ramp.
    clear_stats();
    send_frame(0, BEATS, 1, 1);
    repeat (2) @(negedge clk);
    check("stall_valid_cnt", valid_cnt, 6);
    check("stall_fd_cnt",    fd_cnt, 1);
    check("stall_last_br",   last_win[8][1], 55);

    // Abort at row 2, k = 2 with a fresh sof.
    clear_stats();
    send_frame(0, 10, 1, 0);
    repeat (2) @(negedge clk);
    check("abort_valid_cnt", valid_cnt, 1);
    check("abort_fd_cnt",    fd_cnt, 0);
    clear_stats();
    send_frame(0, BEATS, 1, 0);
    repeat (2) @(negedge clk);
    check("restart_valid_cnt", valid_cnt, 6);
    check("restart_fd_cnt",    fd_cnt, 1);
    check("restart_first_l0",  first_win[0][0], 0);

    // Asynchronous reset between edges, mid-frame.
    send_frame(0, 11, 1, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_zero_outputs("arst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_stats();
    send_frame(0, BEATS, 1, 0);
    repeat (2) @(negedge clk);
    check("arst_first_delay", first_cyc - sof_cyc, 9);
    check("arst_valid_cnt",   valid_cnt, 6);
    check("arst_first_l1_br", first_win[8][1], 35);

    // Constant 255 frame.
    const_phase = 1;
    clear_stats();
    send_frame(1, BEATS, 1, 1);
    repeat (2) @(negedge clk);
    const_phase = 0;
    check("const_valid_cnt", valid_cnt, 6);
    check("const_fd_cnt",    fd_cnt, 1);

    // Random pixels with random stalls.
    for (int f = 0; f < 3; f++) begin
      clear_stats();
      send_frame(2, BEATS, 1, 1);
      repeat (2) @(negedge clk);
      check("rand_valid_cnt", valid_cnt, 6);
      check("rand_fd_cnt",    fd_cnt, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
